// File: rtl/divide_sequencer_pkg.sv
// Shared definitions for the divide sequencer: FSM state encoding and the
// end-to-end latency constant used by anything that has to time a result.
package divide_sequencer_pkg;

  // Two-bit binary encoding of the sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  // Default operand width and the matching accept-to-o_valid latency.
  localparam int DEFAULT_N   = 8;
  localparam int DIV_LATENCY = DEFAULT_N + 2;

  // Accept-to-o_valid latency for an arbitrary width: one LOAD cycle, N divider
  // cycles, and one cycle to register the result.
  function automatic int div_latency(input int n);
    return n + 2;
  endfunction

endpackage : divide_sequencer_pkg

// File: rtl/divide_sequencer_cond_negate.sv
// N-bit two's-complement conditional negation. Used for operand magnitudes on
// the way into the divider and for re-applying signs on the way out.
module cond_negate
  import divide_sequencer_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         i_neg,
  input  logic [N-1:0] i_value,
  output logic [N-1:0] o_value
);

  // Negating the most-negative value wraps back to itself, which is exactly
  // what both the magnitude path (read as unsigned) and the overflow result need.
  assign o_value = i_neg ? (-i_value) : i_value;

endmodule : cond_negate

// File: rtl/divide_sequencer.sv
// Request/response wrapper around the N-cycle shift-subtract divider. Converts
// signed operands to magnitudes, owns the divider start/finished handshake,
// short-circuits divide-by-zero, and re-applies signs to the results.
module divide_sequencer
  import divide_sequencer_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         i_clock,
  input  logic         i_reset,
  // upstream request
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_signed,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  // downstream response
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_undefined,
  output logic         o_overflow,
  // divider side
  output logic         o_div_reset,
  output logic         o_div_start,
  output logic [N-1:0] o_div_dividend,
  output logic [N-1:0] o_div_divisor,
  input  logic         i_div_finished,
  input  logic [N-1:0] i_div_quotient,
  input  logic [N-1:0] i_div_remainder
);

  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

  seq_state_t   r_state;
  seq_state_t   w_next;

  // Latched operand information for the operation in flight.
  logic         r_sa;
  logic         r_sb;
  logic         r_ovf_pending;
  logic [N-1:0] r_mag_a;
  logic [N-1:0] r_mag_b;

  // Registered results presented while in DONE.
  logic [N-1:0] r_quotient;
  logic [N-1:0] r_remainder;
  logic         r_undefined;
  logic         r_overflow;

  logic         w_accept;
  logic         w_div_zero;
  logic         w_sa;
  logic         w_sb;
  logic         w_finish;
  logic [N-1:0] w_mag_a;
  logic [N-1:0] w_mag_b;
  logic [N-1:0] w_quotient;
  logic [N-1:0] w_remainder;

  assign w_accept   = o_ready & i_valid;
  assign w_div_zero = (i_divisor == '0);
  assign w_sa       = i_signed & i_dividend[N-1];
  assign w_sb       = i_signed & i_divisor[N-1];
  assign w_finish   = (r_state == ST_WAIT) & i_div_finished;

  // Operand magnitudes; the most-negative value maps to 2^(N-1) read unsigned.
  cond_negate #(.N(N)) u_neg_dividend (
    .i_neg   (w_sa),
    .i_value (i_dividend),
    .o_value (w_mag_a)
  );

  cond_negate #(.N(N)) u_neg_divisor (
    .i_neg   (w_sb),
    .i_value (i_divisor),
    .o_value (w_mag_b)
  );

  // Quotient is negative when the operand signs differ (truncating division).
  cond_negate #(.N(N)) u_neg_quotient (
    .i_neg   (r_sa ^ r_sb),
    .i_value (i_div_quotient),
    .o_value (w_quotient)
  );

  // Remainder takes the sign of the dividend.
  cond_negate #(.N(N)) u_neg_remainder (
    .i_neg   (r_sa),
    .i_value (i_div_remainder),
    .o_value (w_remainder)
  );

  // State register; any reset abandons the operation in flight.
  always_ff @(posedge i_clock) begin
    // NOTE: state and data registers use non-blocking assignments so every
    // flop samples the pre-edge values, regardless of block ordering.
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so no path through the case leaves w_next unassigned,
    // which would otherwise infer a latch.
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = w_div_zero ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: w_next = ST_WAIT;
      ST_WAIT: begin
        if (i_div_finished) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture on accept; held through LOAD, WAIT and DONE so the divider
  // sees a constant divisor while it re-samples it every clock.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_sa          <= 1'b0;
      r_sb          <= 1'b0;
      r_ovf_pending <= 1'b0;
      r_mag_a       <= '0;
      r_mag_b       <= '0;
    end else if (w_accept) begin
      r_sa          <= w_sa;
      r_sb          <= w_sb;
      r_ovf_pending <= i_signed & (i_dividend == MOST_NEG) & (i_divisor == ALL_ONES);
      r_mag_a       <= w_mag_a;
      r_mag_b       <= w_mag_b;
    end
  end

  // Result capture: divide-by-zero fills in directly on accept, otherwise the
  // sign-corrected divider outputs are taken in the finished cycle.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_quotient  <= '0;
      r_remainder <= '0;
      r_undefined <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_accept && w_div_zero) begin
      r_quotient  <= ALL_ONES;
      r_remainder <= i_dividend;
      r_undefined <= 1'b1;
      r_overflow  <= 1'b0;
    end else if (w_finish) begin
      r_quotient  <= w_quotient;
      r_remainder <= w_remainder;
      r_undefined <= 1'b0;
      r_overflow  <= r_ovf_pending;
    end
  end

  assign o_ready        = (r_state == ST_IDLE) & i_reset;
  assign o_valid        = (r_state == ST_DONE);
  assign o_quotient     = r_quotient;
  assign o_remainder    = r_remainder;
  assign o_undefined    = r_undefined;
  assign o_overflow     = r_overflow;

  assign o_div_reset    = ~i_reset;
  assign o_div_start    = (r_state == ST_LOAD);
  assign o_div_dividend = r_mag_a;
  assign o_div_divisor  = r_mag_b;

endmodule : divide_sequencer

// File: tb/tb_divide_sequencer.sv
// Bench for divide_sequencer: a behavioural divider answers the start pulse,
// and a C-style arithmetic model predicts every response.
module tb_divide_sequencer;
  import divide_sequencer_pkg::*;

  localparam int N = DEFAULT_N;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         u;
    logic         o;
  } exp_t;

  logic         i_clock = 1'b0;
  logic         i_reset = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic         i_signed = 1'b0;
  logic [N-1:0] i_dividend = '0;
  logic [N-1:0] i_divisor = '0;
  logic         o_valid;
  logic         i_ready = 1'b0;
  logic [N-1:0] o_quotient;
  logic [N-1:0] o_remainder;
  logic         o_undefined;
  logic         o_overflow;
  logic         o_div_reset;
  logic         o_div_start;
  logic [N-1:0] o_div_dividend;
  logic [N-1:0] o_div_divisor;
  logic         i_div_finished = 1'b0;
  logic [N-1:0] i_div_quotient = '0;
  logic [N-1:0] i_div_remainder = '0;

  int checks = 0;
  int errors = 0;
  int div_cnt = 0;

  divide_sequencer #(.N(N)) dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_signed        (i_signed),
    .i_dividend      (i_dividend),
    .i_divisor       (i_divisor),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_quotient      (o_quotient),
    .o_remainder     (o_remainder),
    .o_undefined     (o_undefined),
    .o_overflow      (o_overflow),
    .o_div_reset     (o_div_reset),
    .o_div_start     (o_div_start),
    .o_div_dividend  (o_div_dividend),
    .o_div_divisor   (o_div_divisor),
    .i_div_finished  (i_div_finished),
    .i_div_quotient  (i_div_quotient),
    .i_div_remainder (i_div_remainder)
  );

  always #5 i_clock = ~i_clock;

  // Behavioural divider: start seen in cycle c -> finished strobe in cycle c+N,
  // with the unsigned quotient/remainder of the presented magnitudes.
  always @(posedge i_clock) begin
    i_div_finished <= 1'b0;
    if (o_div_reset) begin
      div_cnt <= 0;
    end else if (o_div_start) begin
      div_cnt <= N - 1;
    end else if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
      if (div_cnt == 1) begin
        i_div_finished  <= 1'b1;
        i_div_quotient  <= (o_div_divisor == '0) ? '1 : o_div_dividend / o_div_divisor;
        i_div_remainder <= (o_div_divisor == '0) ? o_div_dividend : o_div_dividend % o_div_divisor;
      end
    end
  end

  // Reference: plain integer arithmetic, C-style truncation for signed.
  function automatic exp_t model(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    int   x, y, q, r;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.u = 1'b1;
      e.o = 1'b0;
    end else begin
      if (sgn) begin
        x = $signed(a);
        y = $signed(b);
      end else begin
        x = int'(a);
        y = int'(b);
      end
      q   = x / y;
      r   = x % y;
      e.q = q[N-1:0];
      e.r = r[N-1:0];
      e.u = 1'b0;
      e.o = sgn && (x == -(1 << (N-1))) && (y == -1);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b);
    check("ready_before_accept", o_ready, 1);
    i_valid    = 1'b1;
    i_signed   = sgn;
    i_dividend = a;
    i_divisor  = b;
    @(negedge i_clock);
    i_valid    = 1'b0;
    i_signed   = 1'($urandom);
    i_dividend = N'($urandom);
    i_divisor  = N'($urandom);
  endtask

  // Count cycles until o_valid, watching the start pulse and the held divisor.
  task automatic wait_result(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t         e = model(sgn, a, b);
    logic [N-1:0] mag_b = (sgn && b[N-1]) ? -b : b;
    logic [N-1:0] mag_a = (sgn && a[N-1]) ? -a : a;
    int           lat = 1;
    int           starts = 0;
    while (o_valid !== 1'b1 && lat < 40) begin
      if (o_div_start === 1'b1) begin
        starts++;
        check("div_dividend_mag", o_div_dividend, mag_a);
      end
      if (b != '0) check("div_divisor_held", o_div_divisor, mag_b);
      @(negedge i_clock);
      lat++;
    end
    check("latency", lat, (b == '0) ? 1 : div_latency(N));
    check("start_pulses", starts, (b == '0) ? 0 : 1);
    check("quotient", o_quotient, e.q);
    check("remainder", o_remainder, e.r);
    check("undefined", o_undefined, e.u);
    check("overflow", o_overflow, e.o);
  endtask

  // Hold the result for 'hold' cycles, then complete the handshake.
  task automatic release_result(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b,
                                input int hold);
    exp_t e = model(sgn, a, b);
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", o_valid, 1);
      check("hold_ready_low", o_ready, 0);
      check("hold_quotient", o_quotient, e.q);
      check("hold_remainder", o_remainder, e.r);
      @(negedge i_clock);
    end
    i_ready = 1'b1;
    @(negedge i_clock);
    i_ready = 1'b0;
    check("valid_dropped", o_valid, 0);
    check("ready_after_handshake", o_ready, 1);
  endtask

  task automatic do_op(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b, input int hold);
    start_op(sgn, a, b);
    wait_result(sgn, a, b);
    release_result(sgn, a, b, hold);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge i_clock);
    check("rst_ready", o_ready, 0);
    check("rst_div_reset", o_div_reset, 1);
    check("rst_valid", o_valid, 0);
    check("rst_quotient", o_quotient, 0);
    check("rst_remainder", o_remainder, 0);
    check("rst_undefined", o_undefined, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_div_dividend", o_div_dividend, 0);
    check("rst_div_divisor", o_div_divisor, 0);
    i_reset = 1'b1;
    @(negedge i_clock);
    check("ready_out_of_reset", o_ready, 1);
    check("div_reset_released", o_div_reset, 0);

    // Directed cases.
    do_op(1'b0, 8'd200, 8'd7, 0);
    do_op(1'b1, 8'hF9, 8'h02, 1);
    do_op(1'b1, 8'h07, 8'hFE, 0);
    do_op(1'b1, 8'h80, 8'hFF, 0);
    do_op(1'b0, 8'h80, 8'hFF, 0);
    do_op(1'b0, 8'h5A, 8'h00, 0);
    do_op(1'b1, 8'h80, 8'h00, 2);

    // Back-pressure with a pending request held on i_valid.
    start_op(1'b0, 8'd200, 8'd7);
    wait_result(1'b0, 8'd200, 8'd7);
    i_valid    = 1'b1;
    i_signed   = 1'b1;
    i_dividend = 8'h07;
    i_divisor  = 8'hFE;
    for (int h = 0; h < 5; h++) begin
      check("bp_ready_low", o_ready, 0);
      check("bp_valid", o_valid, 1);
      check("bp_quotient", o_quotient, 8'h1C);
      check("bp_remainder", o_remainder, 8'h04);
      @(negedge i_clock);
    end
    i_ready = 1'b1;
    @(negedge i_clock);
    i_ready = 1'b0;
    check("bp_valid_dropped", o_valid, 0);
    check("bp_ready_next", o_ready, 1);
    @(negedge i_clock);
    i_valid = 1'b0;
    wait_result(1'b1, 8'h07, 8'hFE);
    release_result(1'b1, 8'h07, 8'hFE, 0);

    // Reset during WAIT aborts the operation.
    start_op(1'b0, 8'd200, 8'd7);
    repeat (4) @(negedge i_clock);
    i_reset = 1'b0;
    #1;
    check("abort_div_reset", o_div_reset, 1);
    check("abort_ready_low", o_ready, 0);
    @(negedge i_clock);
    i_reset = 1'b1;
    #1;
    check("abort_ready", o_ready, 1);
    check("abort_div_reset_off", o_div_reset, 0);
    for (int c = 0; c < N + 4; c++) begin
      check("abort_no_valid", o_valid, 0);
      @(negedge i_clock);
    end
    do_op(1'b0, 8'd100, 8'd9, 0);

    // Randomized operations against the arithmetic model.
    for (int k = 0; k < 30; k++) begin
      logic         sgn;
      logic [N-1:0] a;
      logic [N-1:0] b;
      sgn = 1'($urandom);
      a   = N'($urandom);
      b   = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      do_op(sgn, a, b, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_divide_sequencer

// File: doc/divide_sequencer.md
Name: divide_sequencer

Overview:
- Upstream/downstream wrapper around the N-cycle shift-subtract divider. It owns the divider's start/finished handshake and holds operands stable for the whole operation.
- Adds signed (truncating, C-style) division via sign-magnitude conversion and handles divide-by-zero without running the divider.
- Presents a valid/ready request/response interface to the ALU/execute stage.

Parameters:
N, 8, operand/result width; must equal the attached divider's N (N >= 3).

Ports:
i_clock  in  1  clock, all logic on rising edge
i_reset  in  1  reset, synchronous, active-low
i_valid  in  1  request valid
o_ready  out  1  request accepted when i_valid & o_ready
i_signed  in  1  1 = two's-complement operands, 0 = unsigned
i_dividend  in  N  dividend
i_divisor  in  N  divisor
o_valid  out  1  result valid
i_ready  in  1  result consumed when o_valid & i_ready
o_quotient  out  N  final quotient
o_remainder  out  N  final remainder
o_undefined  out  1  divisor was zero
o_overflow  out  1  signed most-negative / -1
o_div_reset  out  1  active-high reset to divider
o_div_start  out  1  divider start pulse
o_div_dividend  out  N  magnitude dividend to divider
o_div_divisor  out  N  magnitude divisor to divider, held constant
i_div_finished  in  1  divider finished strobe (1 cycle)
i_div_quotient  in  N  divider quotient, valid in finished cycle
i_div_remainder  in  N  divider remainder, valid in finished cycle

Behaviour:
- Reset (i_reset=0 at edge):
  - State goes to IDLE. o_valid, o_quotient, o_remainder, o_undefined and o_overflow are 0.
  - Operand registers are cleared.
  - o_div_reset is combinationally 1 while i_reset=0; o_ready is 0 while i_reset=0.
- FSM: IDLE, LOAD, WAIT, DONE. o_ready = (state==IDLE) & i_reset.
- IDLE, on accept:
  - Latch the sign flags: sa = i_signed & dividend[N-1], sb = i_signed & divisor[N-1].
  - Latch the magnitudes: |a| = sa ? -a : a, |b| = sb ? -b : b, each N-bit. abs(most-negative) = 2^(N-1) fits unsigned.
  - If i_divisor==0: go directly to DONE. Quotient = all ones, remainder = i_dividend (raw), undefined=1, overflow=0. o_valid is asserted the cycle after accept and o_div_start is never asserted.
  - Otherwise: go to LOAD.
- LOAD: o_div_start=1 for exactly this one cycle, then go to WAIT.
- WAIT: hold o_div_dividend/o_div_divisor constant (the divider re-samples the divisor every clock). On i_div_finished:
  - qm=i_div_quotient, rm=i_div_remainder.
  - o_quotient <= (sa^sb) ? -qm : qm.
  - o_remainder <= sa ? -rm : rm.
  - o_overflow <= i_signed & a==100..0 & b==11..1.
  - Go to DONE.
- Overflow case: magnitude 2^(N-1) negated wraps to the most-negative value, remainder 0. No special path.
- DONE:
  - o_valid=1 and results stable until i_ready.
  - On handshake go to IDLE; o_valid drops next cycle.
  - A new request may be accepted in the cycle after the handshake, never in the same cycle.
- Latency: accept at cycle t -> o_div_start at t+1 -> finished at t+1+N -> o_valid at t+N+2.
- i_valid/operands are ignored when o_ready=0. i_div_finished outside WAIT is ignored.
- Reset mid-operation (any state): return to IDLE, discard results. o_div_reset=1 clears the divider. No o_valid is produced for the aborted op.
- o_div_dividend/o_div_divisor reset to 0. The divisor port carries the held magnitude in all states except IDLE-after-reset.

Decomposition:
- Shared package: FSM state encoding constants (IDLE, LOAD, WAIT, DONE, 2-bit binary) and a DIV_LATENCY = N+2 constant for benches.
- One natural sub-module: cond_negate (N-bit two's-complement conditional negation). It is combinational, instantiated four times (two operands, quotient, remainder).
- The divider and its shared subtractor are instantiated alongside at the next level up, not inside this block.

Test Plan:
- Unsigned 200/7, i_signed=0 -> q=28 (0x1C), r=4; o_valid exactly 10 cycles after accept; o_div_start high 1 cycle.
- Signed -7/2 (0xF9/0x02) -> q=0xFD (-3), r=0xFF (-1). Signed 7/-2 -> q=0xFD, r=0x01.
- Signed 0x80/0xFF -> q=0x80, r=0x00, o_overflow=1, o_undefined=0. Same operands unsigned -> q=0x00, r=0x80, overflow=0.
- Divisor 0, dividend 0x5A -> q=0xFF, r=0x5A, o_undefined=1, o_valid 1 cycle after accept, o_div_start never 1.
- Back-pressure: i_ready low 5 cycles in DONE -> outputs stable, o_ready=0, a pending i_valid is not accepted. After the handshake the new op is accepted next cycle and completes correctly.
- i_reset=0 for 1 cycle during WAIT -> o_valid stays 0, o_div_reset=1 that cycle, o_ready=1 after release. A following 100/9 returns q=11, r=1.
